// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP adder operand-alignment stage.
package fp_add_pkg;

  localparam int unsigned ALIGN_W = 27;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  typedef struct packed {
    logic               sign_l;
    logic [7:0]         exp_l;
    logic [ALIGN_W-1:0] mant_l;
    logic [ALIGN_W-1:0] mant_s;
    logic               eff_sub;
    logic               special;
    logic [31:0]        special_val;
  } align_pkt_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier: operand class plus hidden significand bit.
module fp_classify
  import fp_add_pkg::*;
(
  input  logic [31:0] value,
  output fp_class_e   cls,
  output logic        hidden
);

  fp32_t f;
  assign f = value;

  always_comb begin
    cls = FP_NORM;
    if (f.exp == '0)
      cls = (f.man == '0) ? FP_ZERO : FP_DENORM;
    else if (f.exp == EXP_MAX)
      cls = (f.man == '0) ? FP_INF : FP_NAN;
  end

  assign hidden = (f.exp != '0);

endmodule

// File: rtl/fp_add_operand_align.sv
// FP adder issue/alignment stage: classify, order by magnitude, align the smaller significand.
// Optional special-value bypass enabled by defining FP_SPECIAL_BYPASS_EN.
module fp_add_operand_align #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned ALIGN_W = 27
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign_l,
  output logic [7:0]         out_exp_l,
  output logic [ALIGN_W-1:0] out_mant_l,
  output logic [ALIGN_W-1:0] out_mant_s,
  output logic               out_eff_sub,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_special,
  output logic [31:0]        out_special_val
);

  import fp_add_pkg::*;

  fp32_t              a, b;
  fp_class_e          cls_a, cls_b, cls_l, cls_s;
  logic               hid_a, hid_b, hid_l, hid_s;
  logic               a_is_l;
  logic               sign_l;
  logic [7:0]         exp_l_raw, exp_s_raw, exp_eff_l, exp_eff_s, shift;
  logic [22:0]        man_l, man_s;
  logic [ALIGN_W-1:0] mant_l_raw, mant_s_raw, mant_s_al, lost_mask;
  logic               special;
  logic [31:0]        special_val;
  align_pkt_t         pkt_in, out_pkt, skid_pkt;
  logic [TAG_W-1:0]   out_tag_q, skid_tag;
  logic               out_valid_q, skid_valid, accept;

  assign a = in_a;
  assign b = in_b;

  fp_classify u_class_a (.value(in_a), .cls(cls_a), .hidden(hid_a));
  fp_classify u_class_b (.value(in_b), .cls(cls_b), .hidden(hid_b));

  // {exp,man} compares as an unsigned integer, so this is the magnitude order.
  assign a_is_l    = (in_a[30:0] >= in_b[30:0]);
  assign sign_l    = a_is_l ? a.sign : b.sign;
  assign exp_l_raw = a_is_l ? a.exp : b.exp;
  assign exp_s_raw = a_is_l ? b.exp : a.exp;
  assign man_l     = a_is_l ? a.man : b.man;
  assign man_s     = a_is_l ? b.man : a.man;
  assign hid_l     = a_is_l ? hid_a : hid_b;
  assign hid_s     = a_is_l ? hid_b : hid_a;
  assign cls_l     = a_is_l ? cls_a : cls_b;
  assign cls_s     = a_is_l ? cls_b : cls_a;

  assign exp_eff_l = (cls_l == FP_ZERO || cls_l == FP_DENORM) ? 8'd1 : exp_l_raw;
  assign exp_eff_s = (cls_s == FP_ZERO || cls_s == FP_DENORM) ? 8'd1 : exp_s_raw;
  assign shift     = exp_eff_l - exp_eff_s;

  assign mant_l_raw = {hid_l, man_l, 3'b000};
  assign mant_s_raw = {hid_s, man_s, 3'b000};

  always_comb begin
    mant_s_al = '0;
    lost_mask = '0;
    if (shift >= 8'(ALIGN_W)) begin
      mant_s_al[0] = |mant_s_raw;
    end else begin
      lost_mask    = ~({ALIGN_W{1'b1}} << shift);
      mant_s_al    = mant_s_raw >> shift;
      mant_s_al[0] = mant_s_al[0] | (|(mant_s_raw & lost_mask)) | mant_s_raw[0];
    end
  end

`ifdef FP_SPECIAL_BYPASS_EN
  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_INF && cls_b == FP_INF && a.sign != b.sign)) begin
      special     = 1'b1;
      special_val = QNAN;
    end else if (cls_a == FP_INF) begin
      special     = 1'b1;
      special_val = in_a;
    end else if (cls_b == FP_INF) begin
      special     = 1'b1;
      special_val = in_b;
    end else if (cls_a == FP_ZERO && cls_b == FP_ZERO) begin
      special     = 1'b1;
      special_val = {a.sign & b.sign, 31'b0};
    end
  end
`else
  assign special     = 1'b0;
  assign special_val = '0;
`endif

  always_comb begin
    pkt_in             = '0;
    pkt_in.sign_l      = sign_l;
    pkt_in.exp_l       = exp_eff_l;
    pkt_in.mant_l      = mant_l_raw;
    pkt_in.mant_s      = mant_s_al;
    pkt_in.eff_sub     = a.sign ^ b.sign;
    pkt_in.special     = special;
    pkt_in.special_val = special_val;
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && !skid_valid;

  // Skid is only ever occupied while the output register is stalled, so it drains first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      out_pkt     <= '0;
      skid_pkt    <= '0;
      out_tag_q   <= '0;
      skid_tag    <= '0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid) begin
        out_pkt     <= skid_pkt;
        out_tag_q   <= skid_tag;
        out_valid_q <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_pkt     <= pkt_in;
        out_tag_q   <= in_tag;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_pkt   <= pkt_in;
      skid_tag   <= in_tag;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_sign_l      = out_pkt.sign_l;
  assign out_exp_l       = out_pkt.exp_l;
  assign out_mant_l      = out_pkt.mant_l;
  assign out_mant_s      = out_pkt.mant_s;
  assign out_eff_sub     = out_pkt.eff_sub;
  assign out_tag         = out_tag_q;
  assign out_special     = out_pkt.special;
  assign out_special_val = out_pkt.special_val;

endmodule

// File: tb/tb_fp_add_operand_align.sv
// Randomized self-checking bench: a 2-deep FIFO scoreboard fed by an arithmetic alignment model.
module tb_fp_add_operand_align;

  localparam logic [31:0] QNAN_VAL = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign_l;
  logic [7:0]  out_exp_l;
  logic [26:0] out_mant_l;
  logic [26:0] out_mant_s;
  logic        out_eff_sub;
  logic [3:0]  out_tag;
  logic        out_special;
  logic [31:0] out_special_val;

  fp_add_operand_align #(.TAG_W(4), .ALIGN_W(27)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign_l(out_sign_l), .out_exp_l(out_exp_l),
    .out_mant_l(out_mant_l), .out_mant_s(out_mant_s),
    .out_eff_sub(out_eff_sub), .out_tag(out_tag),
    .out_special(out_special), .out_special_val(out_special_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign_l;
    logic [7:0]  exp_l;
    logic [26:0] mant_l;
    logic [26:0] mant_s;
    logic        eff_sub;
    logic [3:0]  tag;
    logic        special;
    logic [31:0] sval;
  } exp_t;

  exp_t       q[$];
  logic [3:0] delivered[$];
  int         total = 0;
  int         bad = 0;
  logic       acc_flag;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Alignment computed with integer arithmetic: divide-by-shift and a remainder test for sticky.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    exp_t e;
    logic [31:0] l, s;
    longint unsigned el, es, sl, ss, d, ms, qv, lost;
    if (a[30:0] >= b[30:0]) begin l = a; s = b; end
    else begin l = b; s = a; end
    el = (l[30:23] == 0) ? 1 : longint'(l[30:23]);
    es = (s[30:23] == 0) ? 1 : longint'(s[30:23]);
    sl = longint'(l[22:0]) + ((l[30:23] != 0) ? 64'd8388608 : 64'd0);
    ss = longint'(s[22:0]) + ((s[30:23] != 0) ? 64'd8388608 : 64'd0);
    ms = ss * 8;
    d  = el - es;
    if (d >= 27) begin
      e.mant_s = (ms != 0) ? 27'd1 : 27'd0;
    end else begin
      qv   = ms / (64'd1 << d);
      lost = ms - qv * (64'd1 << d);
      e.mant_s = 27'(qv | ((lost != 0) ? 64'd1 : 64'd0));
    end
    e.mant_l  = 27'(sl * 8);
    e.exp_l   = 8'(el);
    e.sign_l  = l[31];
    e.eff_sub = a[31] ^ b[31];
    e.tag     = t;
    e.special = 1'b0;
    e.sval    = '0;
`ifdef FP_SPECIAL_BYPASS_EN
    begin
      bit nan_a, nan_b, inf_a, inf_b;
      nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      inf_a = (a[30:0] == 31'h7F800000);
      inf_b = (b[30:0] == 31'h7F800000);
      if (nan_a || nan_b || (inf_a && inf_b && a[31] != b[31])) begin
        e.special = 1'b1; e.sval = QNAN_VAL;
      end else if (inf_a) begin
        e.special = 1'b1; e.sval = a;
      end else if (inf_b) begin
        e.special = 1'b1; e.sval = b;
      end else if (a[30:0] == 0 && b[30:0] == 0) begin
        e.special = 1'b1; e.sval = {a[31] & b[31], 31'b0};
      end
    end
`endif
    return e;
  endfunction

  // One clock: sample at negedge, update scoreboard, return 1 time unit after the posedge.
  task automatic tick();
    int  pre;
    bit  do_pop, do_push;
    @(negedge clk);
    pre = q.size();
    check_val("in_ready", in_ready, pre < 2);
    check_val("out_valid", out_valid, pre != 0);
    if (out_valid && pre != 0) begin
      check_val("sign_l", out_sign_l, q[0].sign_l);
      check_val("exp_l", out_exp_l, q[0].exp_l);
      check_val("mant_l", out_mant_l, q[0].mant_l);
      check_val("mant_s", out_mant_s, q[0].mant_s);
      check_val("eff_sub", out_eff_sub, q[0].eff_sub);
      check_val("tag", out_tag, q[0].tag);
      check_val("special", out_special, q[0].special);
      check_val("special_val", out_special_val, q[0].sval);
    end
    do_pop  = (pre != 0) && out_ready;
    do_push = in_valid && (pre < 2);
    if (do_pop) begin
      delivered.push_back(q[0].tag);
      void'(q.pop_front());
    end
    if (do_push) q.push_back(model(in_a, in_b, in_tag));
    acc_flag = do_push;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic [7:0] e_exp,
                          input logic [26:0] e_ms, input logic e_sign, input logic e_sub);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = 4'hA; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_val("dir_valid", out_valid, 1);
    check_val("dir_exp_l", out_exp_l, e_exp);
    check_val("dir_mant_l", out_mant_l, 27'h4000000);
    check_val("dir_mant_s", out_mant_s, e_ms);
    check_val("dir_sign_l", out_sign_l, e_sign);
    check_val("dir_eff_sub", out_eff_sub, e_sub);
    tick();
  endtask

  function automatic logic [31:0] rand_op(input logic [31:0] ref_op);
    logic [31:0] r;
    int          e;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:0] = '0;
      1: r[30:23] = '0;
      2: begin
        r[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) r[22:0] = '0;
      end
      3, 4, 5: begin
        e = int'(ref_op[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 0) e = 0;
        if (e > 254) e = 254;
        r[30:23] = 8'(e);
      end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    // Reset state
    #12;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_mant_l", out_mant_l, 0);
    check_val("rst_tag", out_tag, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    directed(32'h3F800000, 32'h3F800000, 8'd127, 27'h4000000, 1'b0, 1'b0);
    directed(32'h3F800000, 32'h30800000, 8'd127, 27'h0000001, 1'b0, 1'b0);
    directed(32'hC0000000, 32'h3F800000, 8'd128, 27'h2000000, 1'b1, 1'b1);

    // inf + (-inf)
    in_valid = 1'b1; in_a = 32'h7F800000; in_b = 32'hFF800000; in_tag = 4'h5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef FP_SPECIAL_BYPASS_EN
    check_val("inf_special", out_special, 1);
    check_val("inf_special_val", out_special_val, QNAN_VAL);
`else
    check_val("inf_special", out_special, 0);
    check_val("inf_special_val", out_special_val, 0);
`endif
    tick();

    // Stall with three back-to-back pairs, then release
    delivered.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_tag = 4'(k); in_a = $urandom; in_b = $urandom;
      tick();
    end
    check_val("stall_in_ready", in_ready, 0);
    in_tag = 4'd2; in_a = $urandom; in_b = $urandom;
    tick();
    out_ready = 1'b1;
    for (int n = 0; n < 10 && q.size() != 0; n++) begin
      tick();
      if (acc_flag) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check_val("order_count", delivered.size(), 3);
    for (int k = 0; k < 3 && k < delivered.size(); k++)
      check_val("order_tag", delivered[k], k);

    // Reset asserted with both slots full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_tag = 4'(k + 8); in_a = $urandom; in_b = $urandom;
      tick();
    end
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_val("async_rst_out_valid", out_valid, 0);
    check_val("async_rst_in_ready", in_ready, 1);
    q.delete();
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      in_a      = $urandom;
      in_a      = rand_op(in_a);
      in_b      = rand_op(in_a);
      if ($urandom_range(0, 7) == 0) in_b = in_a ^ {$urandom_range(0, 1) == 1, 31'b0};
      in_tag    = 4'($urandom);
      tick();
    end

    // Drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) tick();
    check_val("drain_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
